// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed 7-segment scanner with frame snapshots, leading-zero blanking and PWM brightness
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   in          4*NDIG hex nibbles, digit 0 rightmost
//   dp_in       per-digit decimal point request (1 = lit)
//   en_in       per-digit enable (0 = dark)
//   lzb         leading-zero blanking enable
//   bright      brightness 0..15 (duty (bright+1)/16)
//   an          anodes, active-low, registered
//   out         segments {g,f,e,d,c,b,a}, active-low, registered
//   dp          decimal point, active-low, registered
//   frame_start one-cycle pulse when a new frame's snapshot is taken
module seg7_scanner #(
    parameter int NDIG  = 8,
    parameter int DIV_W = 17
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [4*NDIG-1:0] in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   en_in,
    input  logic              lzb,
    input  logic [3:0]        bright,
    output logic [7:0]        an,
    output logic [6:0]        out,
    output logic              dp,
    output logic              frame_start
);
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [DIV_W-1:0]  pc;
    logic [2:0]        idx;
    logic              first;
    logic [4*NDIG-1:0] in_s, in_e;
    logic [NDIG-1:0]   dp_s, dp_e, en_s, en_e;
    logic              lzb_s, lzb_e;
    logic [3:0]        br_s, br_e;
    logic              tick, wrap, load, zero_up, on;
    logic [3:0]        nib;
    assign tick = &pc;
    assign wrap = tick && idx == 3'(NDIG - 1);
    assign load = first || wrap;
    // The first cycle out of reset displays the inputs being captured, so frame 0 starts lit
    assign in_e  = first ? in : in_s;
    assign dp_e  = first ? dp_in : dp_s;
    assign en_e  = first ? en_in : en_s;
    assign lzb_e = first ? lzb : lzb_s;
    assign br_e  = first ? bright : br_s;
    assign nib   = in_e[{idx, 2'b00} +: 4];
    always_comb begin
        zero_up = 1'b1;
        for (int k = 0; k < NDIG; k++)
            if (k >= int'(idx) && in_e[4*k +: 4] != 4'h0) zero_up = 1'b0;
        on = en_e[idx] && !(lzb_e && idx != 3'd0 && zero_up) && pc[DIV_W-1 -: 4] <= br_e;
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc          <= '0;
            idx         <= '0;
            first       <= 1'b1;
            in_s        <= '0;
            dp_s        <= '0;
            en_s        <= '0;
            lzb_s       <= 1'b0;
            br_s        <= '0;
            an          <= 8'hFF;
            out         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pc          <= pc + 1'b1;
            idx         <= tick ? (wrap ? 3'd0 : idx + 3'd1) : idx;
            first       <= 1'b0;
            in_s        <= load ? in : in_s;
            dp_s        <= load ? dp_in : dp_s;
            en_s        <= load ? en_in : en_s;
            lzb_s       <= load ? lzb : lzb_s;
            br_s        <= load ? bright : br_s;
            an          <= ~(8'(on) << idx);
            out         <= on ? GLYPH[nib] : 7'h7F;
            dp          <= ~(on && dp_e[idx]);
            frame_start <= load;
        end
    end
endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: randomized scoreboard bench for seg7_scanner (NDIG=4, DIV_W=4)
module tb_seg7_scanner;
    typedef struct packed {
        logic [7:0] an;
        logic [6:0] out;
        logic       dp;
        logic       fs;
    } exp_t;
    logic        clk = 0, clr = 1;
    logic [15:0] in = 0;
    logic [3:0]  dp_in = 0, en_in = 0, bright = 0;
    logic        lzb = 0;
    logic [7:0]  an;
    logic [6:0]  out;
    logic        dp, frame_start;
    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, k = 0;
    logic [15:0] s_in;
    logic [3:0]  s_dp, s_en, s_br;
    logic        s_lzb;
    logic [6:0]  gl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    seg7_scanner #(.NDIG(4), .DIV_W(4)) dut (
        .clk(clk), .clr(clr), .in(in), .dp_in(dp_in), .en_in(en_in),
        .lzb(lzb), .bright(bright), .an(an), .out(out), .dp(dp),
        .frame_start(frame_start)
    );
    always #5 clk = ~clk;
    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask
    task automatic take_snap();
        s_in = in; s_dp = dp_in; s_en = en_in; s_lzb = lzb; s_br = bright;
    endtask
    // Edge k (k>=1 after reset release) shows display time s=k-1: slot (s/16)%4, position s%16.
    // Frames begin at edge 1 and every 64th edge; the frame-0 snapshot is visible immediately.
    task automatic cycle();
        exp_t e;
        int s, d, pcv;
        logic [3:0] nb;
        logic on;
        @(posedge clk); #1;
        k++;
        if (k == 1) take_snap();
        s = k - 1; pcv = s % 16; d = (s / 16) % 4;
        nb = 4'((s_in >> (4 * d)) & 16'hF);
        on = s_en[d] && !(s_lzb && d > 0 && (s_in >> (4 * d)) == 0) && pcv <= int'(s_br);
        e.an  = on ? ~(8'h01 << d) : 8'hFF;
        e.out = on ? gl[nb] : 7'h7F;
        e.dp  = on ? ~s_dp[d] : 1'b1;
        e.fs  = (k == 1) || (k % 64 == 0);
        sb.push_back(e);
        if (k % 64 == 0) take_snap();
    endtask
    task automatic check_reset();
        check("rst_an", an, 8'hFF);
        check("rst_out", out, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_fs", frame_start, 0);
    endtask
    task automatic set_in(logic [15:0] i, logic [3:0] p, logic [3:0] en, logic l, logic [3:0] b);
        in = i; dp_in = p; en_in = en; lzb = l; bright = b;
    endtask
    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("an", an, e.an);
            check("out", out, e.out);
            check("dp", dp, e.dp);
            check("frame_start", frame_start, e.fs);
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        set_in(16'h1234, 4'h0, 4'hF, 0, 4'd15);
        repeat (3) @(posedge clk);
        #3 check_reset();
        @(posedge clk); #1 clr = 0;
        run(130);
        set_in(16'h0070, 4'h0, 4'hF, 1, 4'd15);
        run(130);
        set_in(16'h0000, 4'h0, 4'hF, 1, 4'd15);
        run(130);
        set_in(16'hABCD, 4'h0, 4'hF, 0, 4'd3);
        run(130);
        set_in(16'h5678, 4'b0100, 4'b1011, 0, 4'd15);
        run(130);
        set_in(16'h1111, 4'hF, 4'hF, 0, 4'd15);
        run(84);
        in = 16'h2222;
        run(130);
        // asynchronous reset in the middle of a slot
        run(37);
        @(negedge clk); #2 clr = 1;
        #1 check_reset();
        sb.delete();
        repeat (2) @(posedge clk);
        #3 check_reset();
        @(posedge clk); #1 clr = 0; k = 0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(15) == 0)
                set_in(16'($urandom), 4'($urandom), 4'($urandom_range(15) < 3 ? $urandom : 15),
                       1'($urandom), 4'($urandom));
            if ($urandom_range(31) == 0) in = 16'($urandom) & 16'h00FF;
            cycle();
        end
        @(negedge clk); #1;
        check("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
